// File: rtl/fifo_sync_status.sv
// Synchronous show-ahead FIFO with valid/ready handshakes on both sides.
// It also reports occupancy, programmable almost-full and almost-empty flags,
// and a sticky overflow flag, and it supports a synchronous flush.
// It sits between Sobel pipeline stages to buffer pixel or coefficient streams.
module fifo_sync_status #(
    parameter int unsigned WIDTH_P  = 8,
    parameter int unsigned DEPTH_P  = 16,
    parameter int unsigned AFULL_P  = DEPTH_P - 2,
    parameter int unsigned AEMPTY_P = 2
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       flush_i,
    input  logic [WIDTH_P-1:0]         data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [WIDTH_P-1:0]         data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH_P):0]   count_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH_P);
    localparam int CW = AW + 1;
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH_P-1:0] mem [DEPTH_P];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [CW-1:0]      count_q;
    logic               overflow_q;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;

    // The MSB of each pointer is a wrap bit that separates full from empty when the low bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // ready_o stays low during reset so upstream never sees a handshake it cannot complete.
    assign ready_o = rstn_i & ~full;
    assign valid_o = ~empty;
    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i;

    // The head word is shown ahead of the pop, and it reads as zero when the FIFO is empty.
    assign data_o = valid_o ? mem[rd_ptr[AW-1:0]] : '0;

    assign count_o        = count_q;
    assign almost_full_o  = (count_q >= CW'(AFULL_P));
    assign almost_empty_o = (count_q <= CW'(AEMPTY_P));
    assign overflow_o     = overflow_q;

    // The storage array has no reset, and a word offered during a flush is not written.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
        end
    end

    // Pointer and count update. Flush takes priority and discards any push or pop in the same cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Overflow is sticky once a push is rejected because the FIFO is full. Only a flush or a reset clears it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            overflow_q <= 1'b0;
        end else if (flush_i) begin
            overflow_q <= 1'b0;
        end else if (valid_i && !ready_o) begin
            overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_sync_status.sv
// Bench for fifo_sync_status.
// It runs directed scenarios followed by a randomized phase.
// A queue-based reference model supplies every expected output.
module tb_fifo_sync_status;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AF = D - 2;
    localparam int AE = 2;
    localparam int CW = $clog2(D) + 1;

    logic          clk_i   = 1'b0;
    logic          rstn_i  = 1'b0;
    logic          flush_i = 1'b0;
    logic [W-1:0]  data_i  = '0;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b0;
    logic          ready_o;
    logic [W-1:0]  data_o;
    logic          valid_o;
    logic [CW-1:0] count_o;
    logic          almost_full_o;
    logic          almost_empty_o;
    logic          overflow_o;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q[$];
    logic         m_ovf = 1'b0;

    fifo_sync_status #(
        .WIDTH_P (W),
        .DEPTH_P (D),
        .AFULL_P (AF),
        .AEMPTY_P(AE)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .flush_i       (flush_i),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .count_o       (count_o),
        .almost_full_o (almost_full_o),
        .almost_empty_o(almost_empty_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, " valid_o"},        32'(valid_o),        32'(n > 0));
        chk({tag, " data_o"},         32'(data_o),         (n > 0) ? 32'(q[0]) : 32'd0);
        chk({tag, " count_o"},        32'(count_o),        32'(n));
        chk({tag, " ready_o"},        32'(ready_o),        32'(rstn_i && (n < D)));
        chk({tag, " almost_full_o"},  32'(almost_full_o),  32'(n >= AF));
        chk({tag, " almost_empty_o"}, 32'(almost_empty_o), 32'(n <= AE));
        chk({tag, " overflow_o"},     32'(overflow_o),     32'(m_ovf));
    endtask

    // Reference behaviour at a rising edge, decided from the state before the edge.
    task automatic model_step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        int n;
        logic do_push;
        logic do_pop;
        n = q.size();
        if (!rstn_i || f) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            do_push = v && (n < D);
            do_pop  = r && (n > 0);
            if (v && (n == D)) m_ovf = 1'b1;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic f,
                         input string tag);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        flush_i = f;
        @(negedge clk_i);
        check_all(tag);
        @(posedge clk_i);
        model_step(v, d, r, f);
        #1;
    endtask

    initial begin
        // Power-on reset.
        #12;
        check_all("reset");
        cycle(1'b1, 8'h99, 1'b1, 1'b0, "in reset");
        rstn_i = 1'b1;
        #1;
        check_all("reset release");

        // Scenario 1: fill 0x01..0x10 with the consumer stalled, then drain.
        for (int i = 1; i <= D; i++) cycle(1'b1, W'(i), 1'b0, 1'b0, "t1 fill");
        chk("t1 count full", 32'(count_o), 32'(D));
        chk("t1 ready full", 32'(ready_o), 32'd0);
        for (int i = 1; i <= D; i++) begin
            chk("t1 drain order", 32'(data_o), 32'(i));
            cycle(1'b0, '0, 1'b1, 1'b0, "t1 drain");
        end
        chk("t1 valid after drain", 32'(valid_o), 32'd0);

        // Scenario 2: one-cycle latency, no passthrough when empty.
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, "t2 push");
        chk("t2 data visible", 32'(data_o), 32'hA5);
        cycle(1'b0, '0, 1'b1, 1'b0, "t2 pop");

        // Scenario 3: steady streaming at count 8 across pointer wrap.
        for (int i = 0; i < 8; i++) cycle(1'b1, W'(8'h40 + i), 1'b0, 1'b0, "t3 prefill");
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, W'(8'h80 + i), 1'b1, 1'b0, "t3 stream");
            chk("t3 count held", 32'(count_o), 32'd8);
        end

        // Scenario 4: overflow on a full FIFO, with the rejected word dropped.
        while (q.size() < D) cycle(1'b1, W'($urandom_range(0, 8'hED)), 1'b0, 1'b0, "t4 fill");
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, "t4 overflow push");
        chk("t4 overflow set", 32'(overflow_o), 32'd1);
        chk("t4 count", 32'(count_o), 32'(D));
        while (q.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0, "t4 drain");
        chk("t4 overflow sticky", 32'(overflow_o), 32'd1);

        // Scenario 5: a flush with a handshake on both sides in the same cycle.
        for (int i = 0; i < 5; i++) cycle(1'b1, W'(8'h10 + i), 1'b0, 1'b0, "t5 fill");
        cycle(1'b1, 8'h77, 1'b1, 1'b1, "t5 flush");
        chk("t5 count cleared", 32'(count_o), 32'd0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0, "t5 push33");
        chk("t5 head 0x33", 32'(data_o), 32'h33);
        cycle(1'b0, '0, 1'b1, 1'b0, "t5 pop33");

        // Scenario 6: an asynchronous reset between edges at count 9, with overflow set.
        while (q.size() < D) cycle(1'b1, W'($urandom), 1'b0, 1'b0, "t6 fill");
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, "t6 overflow push");
        while (q.size() > 9) cycle(1'b0, '0, 1'b1, 1'b0, "t6 drain");
        #2;
        rstn_i = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        #1;
        check_all("t6 async reset");
        cycle(1'b1, 8'h55, 1'b1, 1'b0, "t6 held in reset");
        cycle(1'b1, 8'h56, 1'b1, 1'b0, "t6 held in reset");
        #2;
        rstn_i = 1'b1;
        #1;
        check_all("t6 release");

        // Randomized phase with alternating bias, so the FIFO reaches both full and empty.
        for (int i = 0; i < 3000; i++) begin
            int pv;
            int pr;
            logic v;
            logic r;
            logic f;
            pv = ((i / 200) % 2 == 0) ? 80 : 30;
            pr = ((i / 200) % 2 == 0) ? 30 : 80;
            v  = ($urandom_range(0, 99) < pv);
            r  = ($urandom_range(0, 99) < pr);
            f  = ($urandom_range(0, 99) < 2);
            cycle(v, W'($urandom), r, f, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
